// File: rtl/gshare_predictor_if.sv
// Lookup/train bundle between the fetch pipeline and the gshare direction predictor.
// The pipeline side is the master; the predictor is the slave.
interface gshare_predictor_if #(
   parameter int IDX_W  = 5,
   parameter int HIST_W = 5
);
   logic [IDX_W-1:0]  rd_idx;
   logic              pred_taken;
   logic              pred_strong;
   logic [HIST_W-1:0] pred_hist;
   logic              busy;
   logic              upd_en;
   logic [IDX_W-1:0]  upd_idx;
   logic [HIST_W-1:0] upd_hist;
   logic              upd_taken;

   modport master (
      output rd_idx, upd_en, upd_idx, upd_hist, upd_taken,
      input  pred_taken, pred_strong, pred_hist, busy
   );

   modport slave (
      input  rd_idx, upd_en, upd_idx, upd_hist, upd_taken,
      output pred_taken, pred_strong, pred_hist, busy
   );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch direction predictor: saturating-counter table, global history
// register and a post-reset sweep that clears every counter to weakly-not-taken.
module gshare_predictor #(
   parameter int IDX_W  = 5,
   parameter int CNT_W  = 2,
   parameter int HIST_W = 5,
   parameter bit GSHARE = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   gshare_predictor_if.slave   bus
);

   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_WNT  = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [IDX_W-1:0] PTR_LAST = {IDX_W{1'b1}};

   typedef enum logic {
      S_INIT  = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [IDX_W-1:0]  ptr_q;
   logic [HIST_W-1:0] ghr_q;
   logic [HIST_W-1:0] ghr_next;
   logic [CNT_W-1:0]  mem [DEPTH];

   logic              busy;
   logic              sweep_we;
   logic              train_we;
   logic [IDX_W-1:0]  ridx;
   logic [IDX_W-1:0]  widx;
   logic [CNT_W-1:0]  rd_cnt;
   logic [CNT_W-1:0]  wr_cnt;
   logic [CNT_W-1:0]  cnt_next;

   // History is zero-extended into the low index bits before folding.
   function automatic logic [IDX_W-1:0] hash_idx(input logic [IDX_W-1:0]  pc_idx,
                                                 input logic [HIST_W-1:0] hist);
      logic [IDX_W-1:0] hist_ext;
      hist_ext = '0;
      hist_ext[HIST_W-1:0] = hist;
      return GSHARE ? (pc_idx ^ hist_ext) : pc_idx;
   endfunction

   function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt,
                                                 input logic             taken);
      logic [CNT_W-1:0] res;
      res = cnt;
      if (taken && (cnt != CNT_MAX)) begin
         res = cnt + 1'b1;
      end else if (!taken && (cnt != '0)) begin
         res = cnt - 1'b1;
      end
      return res;
   endfunction

   function automatic logic [HIST_W-1:0] shift_hist(input logic [HIST_W-1:0] hist,
                                                    input logic              taken);
      logic [HIST_W:0] wide;
      wide = {hist, taken};
      return wide[HIST_W-1:0];
   endfunction

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic: the sweep ends on the edge that writes the last entry
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:  if (ptr_q == PTR_LAST) state_d = S_READY;
         S_READY: state_d = S_READY;
         default: state_d = S_INIT;
      endcase
   end

   // FSM outputs: the sweep and training share the single write port, never together
   always_comb begin
      busy     = 1'b0;
      sweep_we = 1'b0;
      train_we = 1'b0;
      case (state_q)
         S_INIT: begin
            busy     = 1'b1;
            sweep_we = rst_n;
         end
         S_READY: begin
            train_we = rst_n & bus.upd_en;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (sweep_we) begin
         ptr_q <= ptr_q + 1'b1;
      end
   end

   // History only advances on resolved branches, so it never needs repair
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ghr_q <= '0;
      end else if (train_we) begin
         ghr_q <= ghr_next;
      end
   end

   always_comb begin
      ridx     = hash_idx(bus.rd_idx, ghr_q);
      widx     = hash_idx(bus.upd_idx, bus.upd_hist);
      rd_cnt   = mem[ridx];
      wr_cnt   = mem[widx];
      cnt_next = sat_step(wr_cnt, bus.upd_taken);
      ghr_next = shift_hist(ghr_q, bus.upd_taken);
   end

   // Counter table: no bypass, a lookup in the training cycle sees the old value
   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem[ptr_q] <= CNT_WNT;
      end else if (train_we) begin
         mem[widx] <= cnt_next;
      end
   end

   assign bus.busy        = busy;
   assign bus.pred_hist   = ghr_q;
   assign bus.pred_taken  = !busy && rd_cnt[CNT_W-1];
   assign bus.pred_strong = !busy && ((rd_cnt == '0) || (rd_cnt == CNT_MAX));

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: a bimodal and a gshare instance driven in
// lock-step and compared against an integer-array reference model.
module tb_gshare_predictor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rd_idx = '0;
   logic       upd_en = 1'b0;
   logic [4:0] upd_idx = '0;
   logic [4:0] upd_hist = '0;
   logic       upd_taken = 1'b0;

   int n_pass = 0;
   int n_total = 0;

   // Reference model: counter values as plain integers, history as an integer
   int mb [32];
   int mg [32];
   int m_ghr = 0;
   int m_init_left = 32;

   always #5 clk = ~clk;

   gshare_predictor_if #(.IDX_W(5), .HIST_W(5)) bif ();
   gshare_predictor_if #(.IDX_W(5), .HIST_W(5)) gif ();

   assign bif.rd_idx = rd_idx;   assign gif.rd_idx = rd_idx;
   assign bif.upd_en = upd_en;   assign gif.upd_en = upd_en;
   assign bif.upd_idx = upd_idx; assign gif.upd_idx = upd_idx;
   assign bif.upd_hist = upd_hist; assign gif.upd_hist = upd_hist;
   assign bif.upd_taken = upd_taken; assign gif.upd_taken = upd_taken;

   gshare_predictor #(.IDX_W(5), .CNT_W(2), .HIST_W(5), .GSHARE(1'b0)) u_bim (
      .clk(clk), .rst_n(rst_n), .bus(bif.slave));
   gshare_predictor #(.IDX_W(5), .CNT_W(2), .HIST_W(5), .GSHARE(1'b1)) u_gsh (
      .clk(clk), .rst_n(rst_n), .bus(gif.slave));

   function automatic int clamp3(int v);
      return (v < 0) ? 0 : ((v > 3) ? 3 : v);
   endfunction

   function automatic int exp_taken(int cnt);
      return (m_init_left > 0) ? 0 : ((cnt >= 2) ? 1 : 0);
   endfunction

   function automatic int exp_strong(int cnt);
      return (m_init_left > 0) ? 0 : ((cnt == 0 || cnt == 3) ? 1 : 0);
   endfunction

   // Advance the model by the current inputs, then let the DUT take the same edge.
   task automatic tick();
      int wb, wg;
      if (!rst_n) begin
         m_init_left = 32;
         m_ghr = 0;
      end else if (m_init_left > 0) begin
         mb[32 - m_init_left] = 1;
         mg[32 - m_init_left] = 1;
         m_init_left--;
      end else if (upd_en) begin
         wb = upd_idx;
         wg = upd_idx ^ upd_hist;
         mb[wb] = clamp3(mb[wb] + (upd_taken ? 1 : -1));
         mg[wg] = clamp3(mg[wg] + (upd_taken ? 1 : -1));
         m_ghr = ((m_ghr << 1) | upd_taken) & 31;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic train(int idx, int hist, bit taken);
      upd_en = 1'b1; upd_idx = idx[4:0]; upd_hist = hist[4:0]; upd_taken = taken;
      tick();
      upd_en = 1'b0;
   endtask

   task automatic do_reset_and_sweep();
      rst_n = 1'b0; upd_en = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      repeat (32) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      n_total++;
      if (bif.busy !== 1'b1 || gif.busy !== 1'b1) begin
         $display("FAIL reset_busy: got %b/%b expected 1", bif.busy, gif.busy);
      end else n_pass++;
      rst_n = 1'b1;
      // Training is offered on every sweep cycle and must be ignored
      for (int i = 0; i < 32; i++) begin
         upd_en = 1'b1; upd_taken = 1'b1;
         upd_idx = 5'($urandom_range(0, 31)); upd_hist = 5'($urandom_range(0, 31));
         #1;
         n_total++;
         if (bif.busy !== 1'b1 || gif.busy !== 1'b1) begin
            $display("FAIL sweep_busy cycle %0d: got %b/%b expected 1", i, bif.busy, gif.busy);
         end else n_pass++;
         tick();
      end
      upd_en = 1'b0;
      n_total++;
      if (bif.busy !== 1'b0 || gif.busy !== 1'b0) begin
         $display("FAIL sweep_end: busy got %b/%b expected 0", bif.busy, gif.busy);
      end else n_pass++;
      for (int i = 0; i < 32; i++) begin
         rd_idx = 5'(i);
         #1;
         n_total++;
         if ({bif.pred_taken, bif.pred_strong, gif.pred_taken, gif.pred_strong} !== 4'b0000 ||
             gif.pred_hist !== 5'd0 || bif.pred_hist !== 5'd0) begin
            $display("FAIL init_state idx %0d: got b=%b%b g=%b%b hist=%0d expected 00 00 0",
                     i, bif.pred_taken, bif.pred_strong, gif.pred_taken, gif.pred_strong,
                     gif.pred_hist);
         end else n_pass++;
      end
   endtask

   task automatic test_saturation();
      // Bimodal entry 7 walks WNT -> ST -> SNT and must never wrap
      bit [1:0] want [6];
      int       nsteps [6];
      bit       dir [6];
      want = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b00};
      nsteps = '{3, 2, 1, 3, 1, 1};
      dir = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset_and_sweep();
      rd_idx = 5'd7;
      for (int s = 0; s < 6; s++) begin
         for (int k = 0; k < nsteps[s]; k++) train(7, m_ghr, dir[s]);
         #1;
         n_total++;
         if ({bif.pred_taken, bif.pred_strong} !== want[s]) begin
            $display("FAIL saturation step %0d: got taken,strong=%b%b expected %b",
                     s, bif.pred_taken, bif.pred_strong, want[s]);
         end else n_pass++;
      end
   endtask

   task automatic test_ghr_hash();
      do_reset_and_sweep();
      train(20, m_ghr, 1'b1);
      train(20, m_ghr, 1'b1);
      train(20, m_ghr, 1'b0);
      train(20, m_ghr, 1'b1);
      n_total++;
      if (gif.pred_hist !== 5'b01101 || bif.pred_hist !== 5'b01101) begin
         $display("FAIL ghr_pattern: got %b/%b expected 01101", gif.pred_hist, bif.pred_hist);
      end else n_pass++;
      rd_idx = 5'b01101;
      #1;
      n_total++;
      if ({gif.pred_taken, gif.pred_strong} !== 2'b00) begin
         $display("FAIL hash_entry0_wnt: got %b%b expected 00", gif.pred_taken, gif.pred_strong);
      end else n_pass++;
      train(3, 3, 1'b1);
      train(3, 3, 1'b1);
      // History is now 10111; folding it with the same PC bits lands on entry 0
      rd_idx = 5'b10111;
      #1;
      n_total++;
      if ({gif.pred_taken, gif.pred_strong} !== 2'b11) begin
         $display("FAIL hash_entry0_trained: got %b%b expected 11", gif.pred_taken, gif.pred_strong);
      end else n_pass++;
      rd_idx = 5'd3;
      #1;
      n_total++;
      if ({bif.pred_taken, bif.pred_strong} !== 2'b11) begin
         $display("FAIL bimodal_entry3: got %b%b expected 11", bif.pred_taken, bif.pred_strong);
      end else n_pass++;
      rd_idx = 5'd0;
      #1;
      n_total++;
      if ({bif.pred_taken, bif.pred_strong} !== 2'b00) begin
         $display("FAIL bimodal_entry0: got %b%b expected 00", bif.pred_taken, bif.pred_strong);
      end else n_pass++;
   endtask

   task automatic test_collision();
      do_reset_and_sweep();
      rd_idx = 5'd4;
      upd_en = 1'b1; upd_idx = 5'd4; upd_hist = 5'd0; upd_taken = 1'b1;
      #1;
      n_total++;
      if (bif.pred_taken !== 1'b0 || gif.pred_hist !== 5'd0) begin
         $display("FAIL collision_same_cycle: got taken=%b hist=%0d expected 0 0",
                  bif.pred_taken, gif.pred_hist);
      end else n_pass++;
      tick();
      upd_en = 1'b0;
      #1;
      n_total++;
      if (bif.pred_taken !== 1'b1 || gif.pred_hist !== 5'd1) begin
         $display("FAIL collision_next_cycle: got taken=%b hist=%0d expected 1 1",
                  bif.pred_taken, gif.pred_hist);
      end else n_pass++;
   endtask

   task automatic test_mid_sweep_reset();
      int busy_cycles;
      for (int i = 0; i < 6; i++) train(i, m_ghr, 1'b1);
      rst_n = 1'b0; tick(); tick();
      rst_n = 1'b1;
      repeat (10) tick();
      rst_n = 1'b0; tick(); tick();
      rst_n = 1'b1;
      busy_cycles = 0;
      while (bif.busy === 1'b1 && busy_cycles < 100) begin
         busy_cycles++;
         tick();
      end
      n_total++;
      if (busy_cycles != 32) begin
         $display("FAIL mid_sweep_busy_len: got %0d cycles expected 32", busy_cycles);
      end else n_pass++;
      for (int i = 0; i < 32; i++) begin
         rd_idx = 5'(i);
         #1;
         n_total++;
         if ({bif.pred_taken, bif.pred_strong, gif.pred_taken, gif.pred_strong} !== 4'b0000 ||
             gif.pred_hist !== 5'd0) begin
            $display("FAIL mid_sweep_cleared idx %0d: got b=%b%b g=%b%b hist=%0d expected 0",
                     i, bif.pred_taken, bif.pred_strong, gif.pred_taken, gif.pred_strong,
                     gif.pred_hist);
         end else n_pass++;
      end
   endtask

   task automatic test_random();
      int gi;
      for (int c = 0; c < 400; c++) begin
         rd_idx    = 5'($urandom_range(0, 31));
         upd_en    = ($urandom_range(0, 3) != 0);
         upd_idx   = 5'($urandom_range(0, 7));
         upd_taken = ($urandom_range(0, 2) != 0);
         upd_hist  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(m_ghr);
         #1;
         gi = rd_idx ^ m_ghr;
         n_total++;
         if (bif.pred_taken !== 1'(exp_taken(mb[rd_idx])) ||
             bif.pred_strong !== 1'(exp_strong(mb[rd_idx])) ||
             gif.pred_taken !== 1'(exp_taken(mg[gi])) ||
             gif.pred_strong !== 1'(exp_strong(mg[gi])) ||
             gif.pred_hist !== 5'(m_ghr) || bif.pred_hist !== 5'(m_ghr) ||
             gif.busy !== (m_init_left > 0)) begin
            $display("FAIL random cycle %0d: got b=%b%b g=%b%b hist=%0d expected b=%0d%0d g=%0d%0d hist=%0d",
                     c, bif.pred_taken, bif.pred_strong, gif.pred_taken, gif.pred_strong,
                     gif.pred_hist, exp_taken(mb[rd_idx]), exp_strong(mb[rd_idx]),
                     exp_taken(mg[gi]), exp_strong(mg[gi]), m_ghr);
         end else n_pass++;
         tick();
      end
      upd_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mb[i] = 1;
         mg[i] = 1;
      end
      test_reset();
      test_saturation();
      test_ghr_hash();
      test_collision();
      test_mid_sweep_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "timeout");
   end

endmodule
